// File: rtl/mul_sat_pipe.sv
// mul_sat_pipe: pipelined signed multiplier with handshake,
// scaling shift, optional round-half-up and saturation.
module mul_sat_pipe #(
   parameter int AW    = 24,
   parameter int BW    = 35,
   parameter int OW    = 24,
   parameter int SHIFT = 34,
   parameter int LAT   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [AW-1:0]    a,
   input  logic signed [BW-1:0]    b,
   input  logic [1:0]              mode,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [AW+BW-1:0] p_full,
   output logic signed [OW-1:0]    p,
   output logic                    ovf
);

   localparam int FW = AW + BW;
   localparam int EW = FW + 1;
   localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [EW-1:0] HALF =
      (SHIFT > 0) ? (EW'(1) << HS) : '0;
   localparam logic signed [EW-1:0] MAXV =
      {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV = ~MAXV;

   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   logic                 s1_v;
   logic signed [AW-1:0] s1_a;
   logic signed [BW-1:0] s1_b;
   logic [1:0]           s1_mode;

   // operand capture stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v    <= 1'b0;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_mode <= '0;
      end else if (!stall) begin
         s1_v    <= in_valid;
         s1_a    <= a;
         s1_b    <= b;
         s1_mode <= mode;
      end
   end

   logic signed [FW-1:0] prod;
   assign prod = FW'(s1_a) * FW'(s1_b);

   logic signed [FW-1:0] src_full;
   logic [1:0]           src_mode;
   logic                 src_v;

   if (LAT == 2) begin : g_direct
      assign src_full = prod;
      assign src_mode = s1_mode;
      assign src_v    = s1_v;
   end else begin : g_mid
      localparam int D = LAT - 2;
      logic signed [FW-1:0] m_full [D];
      logic [1:0]           m_mode [D];
      logic                 m_v    [D];

      // product formation and carry stages; retimeable
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < D; i++) begin
               m_v[i]    <= 1'b0;
               m_full[i] <= '0;
               m_mode[i] <= '0;
            end
         end else if (!stall) begin
            m_v[0]    <= s1_v;
            m_full[0] <= prod;
            m_mode[0] <= s1_mode;
            for (int i = 1; i < D; i++) begin
               m_v[i]    <= m_v[i-1];
               m_full[i] <= m_full[i-1];
               m_mode[i] <= m_mode[i-1];
            end
         end
      end

      assign src_full = m_full[D-1];
      assign src_mode = m_mode[D-1];
      assign src_v    = m_v[D-1];
   end

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] sum;
   logic signed [EW-1:0] t;
   logic                 hi;
   logic                 lo;
   logic signed [OW-1:0] p_n;

   // scale, round, range check and clamp/wrap
   always_comb begin
      ext = EW'(src_full);
      sum = ext + (src_mode[0] ? HALF : '0);
      t   = sum >>> SHIFT;
      hi  = t > MAXV;
      lo  = t < MINV;
      p_n = t[OW-1:0];
      if (src_mode[1] && hi) p_n = MAXV[OW-1:0];
      else if (src_mode[1] && lo) p_n = MINV[OW-1:0];
   end

   // output register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         p_full    <= '0;
         p         <= '0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         out_valid <= src_v;
         p_full    <= src_full;
         p         <= p_n;
         ovf       <= hi | lo;
      end
   end

endmodule

// File: tb/tb_mul_sat_pipe.sv
// tb_mul_sat_pipe: directed and random checks of mul_sat_pipe
// at default and reduced parameters against a behavioural model.
module tb_mul_sat_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // default instance
   logic        iv0, irdy0, ov0, ordy0, ovf0;
   logic [23:0] a0, p0;
   logic [34:0] b0;
   logic [1:0]  m0;
   logic [58:0] pf0;

   // reduced instance
   logic        iv1, irdy1, ov1, ordy1, ovf1;
   logic [17:0] a1;
   logic [24:0] b1;
   logic [15:0] p1;
   logic [1:0]  m1;
   logic [42:0] pf1;

   mul_sat_pipe u0 (
      .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(irdy0),
      .a(a0), .b(b0), .mode(m0), .out_valid(ov0),
      .out_ready(ordy0), .p_full(pf0), .p(p0), .ovf(ovf0)
   );

   mul_sat_pipe #(
      .AW(18), .BW(25), .OW(16), .SHIFT(8), .LAT(2)
   ) u1 (
      .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(irdy1),
      .a(a1), .b(b1), .mode(m1), .out_valid(ov1),
      .out_ready(ordy1), .p_full(pf1), .p(p1), .ovf(ovf1)
   );

   typedef struct {
      longint full;
      longint pe;
      bit     ov;
      int     acc;
      int     st;
   } exp_t;

   typedef struct {
      longint      full;
      logic [23:0] p;
      logic        ov;
   } obs_t;

   exp_t q0[$];
   exp_t q1[$];
   obs_t log0[$];
   int st0 = 0, st1 = 0, xf0 = 0, xf1 = 0;

   task automatic chk(input string tag,
                      input logic signed [63:0] o,
                      input logic signed [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
      end
   endtask

   // reference: exact product, scale, round, range, clamp or wrap
   function automatic exp_t model(input longint x, input longint y,
                                  input logic [1:0] md, input int sh,
                                  input int ow, input int acc,
                                  input int st);
      exp_t e;
      longint t, m, r, mx;
      e.full = x * y;
      t = e.full;
      if (md[0] && sh > 0) t = t + (longint'(1) << (sh - 1));
      t = t >>> sh;
      mx = (longint'(1) << (ow - 1)) - 1;
      e.ov = (t > mx) || (t < -mx - 1);
      if (md[1] && t > mx) r = mx;
      else if (md[1] && t < -mx - 1) r = -mx - 1;
      else begin
         m = longint'(1) << ow;
         r = t % m;
         if (r < 0) r = r + m;
         if (r > mx) r = r - m;
      end
      e.pe = r;
      e.acc = acc;
      e.st = st;
      return e;
   endfunction

   always @(negedge clk) begin : mon0
      exp_t e;
      if (rst) q0.delete();
      else begin
         if (ov0 === 1'b1 && ordy0) begin
            xf0++;
            chk("m0_expected", q0.size() > 0, 1);
            if (q0.size() > 0) begin
               e = q0.pop_front();
               chk("m0_pfull", $signed(pf0), e.full);
               chk("m0_p", $signed(p0), e.pe);
               chk("m0_ovf", ovf0, e.ov);
               chk("m0_lat", cyc - e.acc, 3 + st0 - e.st);
               log0.push_back('{$signed(pf0), p0, ovf0});
            end
         end
         if (ov0 && !ordy0) st0++;
         if (iv0 && irdy0)
            q0.push_back(model($signed(a0), $signed(b0), m0,
                               34, 24, cyc + 1, st0));
      end
   end

   always @(negedge clk) begin : mon1
      exp_t e;
      if (rst) q1.delete();
      else begin
         if (ov1 === 1'b1 && ordy1) begin
            xf1++;
            chk("m1_expected", q1.size() > 0, 1);
            if (q1.size() > 0) begin
               e = q1.pop_front();
               chk("m1_pfull", $signed(pf1), e.full);
               chk("m1_p", $signed(p1), e.pe);
               chk("m1_ovf", ovf1, e.ov);
               chk("m1_lat", cyc - e.acc, 1 + st1 - e.st);
            end
         end
         if (ov1 && !ordy1) st1++;
         if (iv1 && irdy1)
            q1.push_back(model($signed(a1), $signed(b1), m1,
                               8, 16, cyc + 1, st1));
      end
   end

   task automatic push0(input logic [23:0] x, input logic [34:0] y,
                        input logic [1:0] md);
      bit acc;
      bit done = 0;
      a0 = x;
      b0 = y;
      m0 = md;
      iv0 = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         acc = irdy0;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1;
            break;
         end
      end
      if (!done) chk("push0_timeout", 0, 1);
   endtask

   task automatic drain0();
      for (int k = 0; k < 300; k++) begin
         if (q0.size() == 0) break;
         @(negedge clk);
      end
      chk("drain0", q0.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain1();
      for (int k = 0; k < 300; k++) begin
         if (q1.size() == 0) break;
         @(negedge clk);
      end
      chk("drain1", q1.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      longint efull [4];
      logic [23:0] sp0, ep;
      logic [58:0] spf;
      logic sov;
      int xb, t0, sent;
      bit acc;

      rst = 1'b0;
      iv0 = 0; a0 = '0; b0 = '0; m0 = '0; ordy0 = 1'b1;
      iv1 = 0; a1 = '0; b1 = '0; m1 = '0; ordy1 = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_async_ov0", ov0, 0);
      chk("rst_async_rdy0", irdy0, 1);
      chk("rst_async_p0", p0, 0);
      chk("rst_async_pf0", pf0, 0);
      chk("rst_async_ovf0", ovf0, 0);
      chk("rst_async_ov1", ov1, 0);
      chk("rst_async_rdy1", irdy1, 1);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_ov0", ov0, 0);
      chk("rst_rdy0", irdy0, 1);
      chk("rst_p0", p0, 0);
      chk("rst_pf0", pf0, 0);
      chk("rst_ovf0", ovf0, 0);

      // directed stream, out_ready held high
      log0.delete();
      push0(24'd1, 35'd1, 2'd0);
      push0(24'd65397, 35'd121375, 2'd0);
      push0(-24'sd65397, 35'd121375, 2'd0);
      push0(-24'sd65397, -35'sd121375, 2'd0);
      for (int md = 0; md < 4; md++)
         push0(24'h400000, 35'h080000000, 2'(md));
      push0(24'd1, 35'h200000000, 2'd0);
      push0(24'd1, 35'h200000000, 2'd1);
      push0(24'hFFFFFF, 35'h200000000, 2'd0);
      push0(24'hFFFFFF, 35'h200000000, 2'd1);
      push0(24'h800000, 35'h400000000, 2'd2);
      push0(24'h800000, 35'h400000000, 2'd0);
      push0(24'h400000, 35'd1, 2'd2);
      iv0 = 1'b0;
      drain0();

      chk("log_size", log0.size(), 15);
      if (log0.size() >= 15) begin
         efull[0] = 64'sd1;
         efull[1] = 64'sd7937560875;
         efull[2] = -64'sd7937560875;
         efull[3] = 64'sd7937560875;
         for (int i = 0; i < 4; i++)
            chk($sformatf("full_%0d", i), log0[i].full, efull[i]);
         for (int i = 4; i < 8; i++)
            chk($sformatf("scale_%0d", i), log0[i].p, 24'h080000);
         chk("pos_floor", log0[8].p, 24'h000000);
         chk("pos_round", log0[9].p, 24'h000001);
         chk("neg_floor", log0[10].p, 24'hFFFFFF);
         chk("neg_round", log0[11].p, 24'h000000);
         chk("sat_p", log0[12].p, 24'h7FFFFF);
         chk("sat_ovf", log0[12].ov, 1);
         chk("wrap_p", log0[13].p, 24'h800000);
         chk("wrap_ovf", log0[13].ov, 1);
         chk("inrange_ovf", log0[14].ov, 0);
      end

      // backpressure: 6 beats, 5 stalled cycles on first result
      xb = xf0;
      fork
         begin
            for (int i = 0; i < 6; i++)
               push0(24'($urandom), 35'({$urandom, $urandom}),
                     2'($urandom));
            iv0 = 1'b0;
         end
         begin
            for (int k = 0; k < 50; k++) begin
               @(posedge clk);
               #1;
               if (ov0) break;
            end
            chk("bp_first_valid", ov0, 1);
            ordy0 = 1'b0;
            sp0 = p0;
            spf = pf0;
            sov = ovf0;
            repeat (5) begin
               @(negedge clk);
               chk("bp_rdy", irdy0, 0);
               chk("bp_ov", ov0, 1);
               chk("bp_pf", pf0, spf);
               chk("bp_p", p0, sp0);
               chk("bp_ovf", ovf0, sov);
               @(posedge clk);
               #1;
            end
            ordy0 = 1'b1;
         end
      join
      drain0();
      chk("bp_count", xf0 - xb, 6);

      // reset with beats in flight
      for (int i = 0; i < 3; i++)
         push0(24'($urandom), 35'($urandom), 2'($urandom));
      iv0 = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_pre_ov", ov0, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_ov", ov0, 0);
      chk("rst_mid_rdy", irdy0, 1);
      chk("rst_mid_pf", pf0, 0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      xb = xf0;
      repeat (8) begin
         @(posedge clk);
         #1;
         chk("rst_no_stale", ov0, 0);
      end
      a0 = 24'd3;
      b0 = 35'd5;
      m0 = 2'd0;
      iv0 = 1'b1;
      @(negedge clk);
      chk("rst_new_rdy", irdy0, 1);
      @(posedge clk);
      #1;
      iv0 = 1'b0;
      t0 = cyc;
      for (int k = 0; k < 20; k++) begin
         if (ov0) break;
         @(posedge clk);
         #1;
      end
      chk("rst_new_lat", cyc - t0, 3);
      chk("rst_new_pf", pf0, 59'd15);
      drain0();
      chk("rst_new_count", xf0 - xb, 1);

      // reduced parameters: random beats, random out_ready
      sent = 0;
      a1 = 18'($urandom);
      b1 = 25'($urandom);
      m1 = 2'($urandom);
      iv1 = 1'b1;
      for (int k = 0; k < 20000 && sent < 1000; k++) begin
         @(negedge clk);
         acc = iv1 && irdy1;
         @(posedge clk);
         #1;
         if (acc) sent++;
         ordy1 = ($urandom % 4) != 0;
         if (acc || !iv1) begin
            iv1 = (sent < 1000) && (($urandom % 4) != 0);
            a1 = 18'($urandom);
            b1 = 25'($urandom);
            m1 = 2'($urandom);
         end
      end
      iv1 = 1'b0;
      ordy1 = 1'b1;
      chk("sweep_sent", sent, 1000);
      drain1();
      chk("sweep_count", xf1, 1000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
